// File: rtl/prog_delay_counter.sv
// prog_delay_counter: programmable delay timer with one-shot and auto-reload
// modes, pause, synchronous abort and asynchronous active-low reset.
// Every output is driven straight from a register.
module prog_delay_counter #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEFAULT_DELAY = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    input  logic             pause,
    input  logic             sync_clear,
    output logic             out,
    output logic             done_pulse,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LP_DEFAULT = WIDTH'(DEFAULT_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_target;
    logic             r_mode;
    logic             r_out;
    logic             r_done_pulse;
    logic             r_busy;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_target_next;
    logic             w_mode_next;
    logic             w_out_next;
    logic             w_done_next;
    logic [WIDTH:0]   w_count_inc;
    logic             w_expire;

    // One extra bit on the increment so the compare against target is exact
    // even when target is the all-ones value.
    assign w_count_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign w_expire    = (w_count_inc == {1'b0, r_target});

    // State and datapath registers; reset restores the default target.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_target     <= LP_DEFAULT;
            r_mode       <= 1'b0;
            r_out        <= 1'b0;
            r_done_pulse <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_target     <= w_target_next;
            r_mode       <= w_mode_next;
            r_out        <= w_out_next;
            r_done_pulse <= w_done_next;
            r_busy       <= (w_state_next == ST_RUN);
        end
    end

    // Next-state logic: sync_clear beats start, start beats counting/expiry.
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_target_next = r_target;
        w_mode_next   = r_mode;
        w_out_next    = r_out;
        w_done_next   = 1'b0;

        if (sync_clear) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
            w_out_next   = 1'b0;
        end else if (start) begin
            w_state_next  = ST_RUN;
            w_count_next  = '0;
            w_out_next    = 1'b0;
            w_target_next = (load_value != '0) ? load_value : LP_DEFAULT;
            w_mode_next   = mode;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (!pause) begin
                        if (w_expire) begin
                            w_done_next = 1'b1;
                            w_out_next  = 1'b1;
                            if (r_mode) begin
                                w_count_next = '0;
                            end else begin
                                w_count_next = r_target;
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            w_count_next = w_count_inc[WIDTH-1:0];
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    w_state_next = r_state;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign out        = r_out;
    assign done_pulse = r_done_pulse;
    assign busy       = r_busy;
    assign count      = r_count;

endmodule

// File: tb/tb_prog_delay_counter.sv
// Scoreboard bench for prog_delay_counter: a run-level reference model pushes
// the expected output snapshot after every rising edge; a monitor pops and
// compares on the falling edge.
module tb_prog_delay_counter;

    localparam int unsigned W   = 8;
    localparam int unsigned DEF = 4;

    logic         clock;
    logic         clear_n;
    logic         start;
    logic [W-1:0] load_value;
    logic         mode;
    logic         pause;
    logic         sync_clear;
    logic         out;
    logic         done_pulse;
    logic         busy;
    logic [W-1:0] count;

    prog_delay_counter #(
        .WIDTH         (W),
        .DEFAULT_DELAY (DEF)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start),
        .load_value (load_value),
        .mode       (mode),
        .pause      (pause),
        .sync_clear (sync_clear),
        .out        (out),
        .done_pulse (done_pulse),
        .busy       (busy),
        .count      (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int cnt;
        bit o;
        bit dp;
        bit b;
    } snap_t;

    snap_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: a run is (target, mode, number of unpaused cycles
    // spent running). Outputs follow from that by plain arithmetic.
    bit m_run, m_fin, m_out, m_pulse, m_mode;
    int m_T      = DEF;
    int m_active = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.cnt = m_fin ? m_T : (m_run ? (m_active % m_T) : 0);
        s.o   = m_out;
        s.dp  = m_pulse;
        s.b   = m_run;
        return s;
    endfunction

    task automatic model_reset();
        m_run = 0; m_fin = 0; m_out = 0; m_pulse = 0; m_mode = 0;
        m_T = DEF; m_active = 0;
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_edge();
        m_pulse = 0;
        if (!clear_n) begin
            model_reset();
        end else if (sync_clear) begin
            m_run = 0; m_fin = 0; m_out = 0; m_active = 0;
        end else if (start) begin
            m_run = 1; m_fin = 0; m_out = 0; m_active = 0;
            m_T = (load_value != 0) ? int'(load_value) : DEF;
            m_mode = mode;
        end else if (m_run && !pause) begin
            m_active++;
            if (m_active % m_T == 0) begin
                m_pulse = 1;
                m_out   = 1;
                if (!m_mode) begin
                    m_run = 0;
                    m_fin = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        q.push_back(model_snap());
        #1;
    endtask

    task automatic drv(input bit st, input int lv, input bit md, input bit ps, input bit sc);
        start      = st;
        load_value = W'(lv);
        mode       = md;
        pause      = ps;
        sync_clear = sc;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0);
    endtask

    // Pulse clear_n between edges and check the outputs drop immediately.
    task automatic do_reset();
        start = 0; sync_clear = 0; pause = 0;
        #1;
        clear_n = 1'b0;
        q.delete();
        model_reset();
        q.push_back(model_snap());
        #1;
        check("async_rst_out",   int'(out),        0);
        check("async_rst_done",  int'(done_pulse), 0);
        check("async_rst_busy",  int'(busy),       0);
        check("async_rst_count", int'(count),      0);
        step();
        clear_n = 1'b1;
    endtask

    // Monitor: compare every predicted snapshot against the live outputs.
    initial begin
        snap_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count",      int'(count),      e.cnt);
                check("out",        int'(out),        int'(e.o));
                check("done_pulse", int'(done_pulse), int'(e.dp));
                check("busy",       int'(busy),       int'(e.b));
            end
        end
    end

    initial begin
        clear_n    = 1'b0;
        start      = 1'b0;
        load_value = '0;
        mode       = 1'b0;
        pause      = 1'b0;
        sync_clear = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        clear_n = 1'b1;

        // one-shot, target 4, then linger in DONE with pause toggling
        drv(1, 4, 0, 0, 0);
        idle(5);
        drv(0, 0, 0, 1, 0);
        drv(0, 0, 0, 1, 0);
        // auto-reload, target 3
        drv(1, 3, 1, 0, 0);
        idle(10);
        drv(0, 0, 0, 0, 1);
        // target 5 with a two-cycle pause mid-run
        drv(1, 5, 0, 0, 0);
        idle(2);
        drv(0, 0, 0, 1, 0);
        drv(0, 0, 0, 1, 0);
        idle(5);
        // default target and target 1
        drv(1, 0, 0, 0, 0);
        idle(5);
        drv(1, 1, 0, 0, 0);
        idle(3);
        // start and sync_clear together, pause in IDLE
        drv(1, 6, 0, 0, 1);
        drv(0, 0, 0, 1, 0);
        idle(1);
        // restart at count 2 of target 6
        drv(1, 6, 0, 0, 0);
        idle(2);
        drv(1, 6, 0, 0, 0);
        idle(8);
        // sync_clear on the expiry cycle
        drv(1, 2, 0, 0, 0);
        drv(0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1);
        idle(2);
        // top-of-range target, one-shot
        drv(1, 255, 0, 0, 0);
        idle(257);
        // async reset at count 3
        drv(1, 6, 0, 0, 0);
        idle(3);
        do_reset();
        idle(8);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                drv($urandom_range(0, 11) == 0,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 7)),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 39) == 0);
            end
        end

        idle(2);
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
